commit_controller: RTL and testbench
====================================

# commit_controller

In-order retirement sequencer between the reorder buffer head and the register file. It pops completed ROB entries one per cycle and drives the register file's commit write port. It holds stores at the head until the load-store unit acknowledges them. On a branch mispredict it broadcasts a flush and then walks the register file clearing every rename constraint.

## Interface
- ROB_WIDTH, 4: ROB index width.
- clockIn  input  1  clock.
- resetIn  input  1  synchronous, active-high reset.
- headValid  input  1  ROB head entry exists.
- headReady  input  1  head result computed.
- headType  input  2  0 = REG, 1 = STORE, 2 = BRANCH, 3 = reserved (treated as REG).
- headDest  input  5  destination register.
- headValue  input  32  result value (link value for BRANCH).
- headRobId  input  ROB_WIDTH  ROB index of the head.
- headMispredict  input  1  BRANCH resolved wrong.
- headTarget  input  32  correct PC for a mispredicted branch.
- headPop  output  1  ROB dequeues head this cycle (combinational).
- regUpdateValid  output  1  register file commit write.
- regUpdateDest  output  5  commit destination.
- regValue  output  32  commit value.
- regUpdateRobId  output  ROB_WIDTH  committing ROB index.
- storeCommitValid  output  1  request to LSB: perform store.
- storeCommitRobId  output  ROB_WIDTH  store's ROB index.
- storeDone  input  1  LSB accepted the store.
- flushOut  output  1  one-cycle pipeline flush pulse.
- flushPc  output  32  redirect PC, valid with flushOut.
- rfClearValid  output  1  clear constraint of rfClearIndex.
- rfClearIndex  output  5  register being cleared.
- busy  output  1  state is not RUN.

## Operation
- States:
  - RUN: normal retirement.
  - STORE_WAIT: store held at head awaiting LSB.
  - FLUSH: constraint walk after a mispredict.
- RUN, headValid && headReady:
  - REG: headPop = 1. Next cycle, regUpdate* carry dest/value/robId; regUpdateValid = 0 if headDest == 0.
  - STORE: no pop. Next state STORE_WAIT; storeCommitValid = 1 from next cycle.
  - BRANCH, !headMispredict: treated as REG (link write when dest != 0).
  - BRANCH, headMispredict: headPop = 1. Link write is issued as for REG. flushOut = 1 and flushPc = headTarget in the next cycle. Next state FLUSH with walk counter = 1.
- RUN, head absent or not ready: no pop, no outputs.
- STORE_WAIT: storeCommitValid held and storeCommitRobId stable until storeDone.
  - On storeDone: headPop = 1 in the same cycle, storeCommitValid drops next cycle, return to RUN.
  - storeDone outside STORE_WAIT is ignored.
- FLUSH:
  - Each cycle: rfClearValid = 1, rfClearIndex = counter, counter increments.
  - After index 31 is issued, return to RUN. The walk is 31 cycles; x0 is never cleared.
  - headPop = 0 throughout. Head inputs are ignored because the ROB is flushing.
- Reset at any point:
  - State returns to RUN and the counter resets to 0.
  - All outputs go to 0: regUpdate*, storeCommit*, flushOut, flushPc, rfClear*, busy.
  - An in-flight store request is abandoned without a pop.

## Timing
- Pop-to-write latency is 1 cycle; register-file-facing outputs are registered.
- Peak rate is one REG commit per cycle with back-to-back pops.
- Store commit takes at least 2 cycles: enter STORE_WAIT, then storeDone.
- Mispredict to resuming RUN:
  - cycle N: pop.
  - cycle N+1: flushOut, link write, first clear (index 1).
  - cycles N+1..N+31: clears of indices 1..31.
  - cycle N+32: RUN; a pop is possible that cycle.
- flushOut is high for exactly one cycle.
- busy is registered and equals (state != RUN).
- headPop is never asserted in two consecutive cycles for the same store.

## Configuration
- COMMIT_COUNTER_EN defined:
  - Adds output commitCount (64 bits), reset to 0.
  - Incremented by 1 on every headPop, including pops of x0-destination entries and stores.
  - Wraps modulo 2^64.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - ROB type constants: TYPE_REG = 2'd0, TYPE_STORE = 2'd1, TYPE_BRANCH = 2'd2.
  - State encoding: RUN, STORE_WAIT, FLUSH.
  - Constant NUM_ARCH_REGS = 32.
- No sub-module: a single FSM plus the walk counter.

## Test plan
- Three ready REG heads with dest 5/6/0 and values 0x11/0x22/0x33 → three consecutive pops; writes to x5 = 0x11 and x6 = 0x22 one cycle later; no write for x0.
- Ready STORE, robId 3, storeDone after 4 cycles → storeCommitValid high for 4 cycles with robId 3; pop only in the storeDone cycle; storeDone while in RUN ignored.
- Mispredicted BRANCH, dest 1, value 0x104, target 0x200 → pop; next cycle write x1 = 0x104, flushOut = 1, flushPc = 0x200; rfClearIndex 1..31 on consecutive cycles; busy high for 31 cycles; no pops during the walk.
- resetIn asserted mid-FLUSH (index 10) and mid-STORE_WAIT → next cycle all outputs 0, state RUN, a new REG commit proceeds normally.
- Head not ready for 5 cycles, then ready → no pops or writes until the ready cycle.
- With COMMIT_COUNTER_EN defined, 2 REG + 1 STORE + 1 mispredict → commitCount = 4.

Source files
------------

// File: rtl/commit_controller_pkg.sv
// Shared ROB type codes, FSM encoding and register-file constants for commit_controller.
package commit_controller_pkg;

  localparam logic [1:0] TYPE_REG    = 2'd0;
  localparam logic [1:0] TYPE_STORE  = 2'd1;
  localparam logic [1:0] TYPE_BRANCH = 2'd2;

  localparam int NUM_ARCH_REGS = 32;
  localparam int REG_IDX_W     = $clog2(NUM_ARCH_REGS);

  // x0 has no rename constraint, so the flush walk starts at index 1.
  localparam logic [REG_IDX_W-1:0] FIRST_CLEAR_IDX = REG_IDX_W'(1);
  localparam logic [REG_IDX_W-1:0] LAST_REG_IDX    = REG_IDX_W'(NUM_ARCH_REGS - 1);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STORE_WAIT = 2'd1,
    ST_FLUSH      = 2'd2
  } state_t;

endpackage

// File: rtl/commit_controller.sv
// In-order retirement sequencer: pops the ROB head, drives the register-file commit port,
// holds stores for the LSB and walks rename constraints after a mispredict. Optional macro: COMMIT_COUNTER_EN.
module commit_controller
  import commit_controller_pkg::*;
#(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 headValid,
  input  logic                 headReady,
  input  logic [1:0]           headType,
  input  logic [4:0]           headDest,
  input  logic [31:0]          headValue,
  input  logic [ROB_WIDTH-1:0] headRobId,
  input  logic                 headMispredict,
  input  logic [31:0]          headTarget,
  output logic                 headPop,
  output logic                 regUpdateValid,
  output logic [4:0]           regUpdateDest,
  output logic [31:0]          regValue,
  output logic [ROB_WIDTH-1:0] regUpdateRobId,
  output logic                 storeCommitValid,
  output logic [ROB_WIDTH-1:0] storeCommitRobId,
  input  logic                 storeDone,
  output logic                 flushOut,
  output logic [31:0]          flushPc,
  output logic                 rfClearValid,
  output logic [4:0]           rfClearIndex,
  output logic                 busy,
`ifdef COMMIT_COUNTER_EN
  output logic [63:0]          commitCount,
`endif
  output state_t               o_dbg_state
);

  // Handshakes: headPop is a one-cycle dequeue strobe to the ROB. storeCommitValid/storeDone
  // is valid/ack: valid stays high with a stable robId until storeDone is seen, then drops.
  state_t                 r_state;
  state_t                 w_next_state;
  logic [REG_IDX_W-1:0]   r_walk_idx;
  logic [REG_IDX_W-1:0]   w_next_walk_idx;

  logic                   w_is_store;
  logic                   w_is_mispredict;
  logic                   w_head_fire;
  logic                   w_run_pop;
  logic                   w_store_ack;
  logic                   w_pop;
  logic                   w_reg_write;
  logic                   w_flush_start;

  logic                   r_reg_valid;
  logic [4:0]             r_reg_dest;
  logic [31:0]            r_reg_value;
  logic [ROB_WIDTH-1:0]   r_reg_rob_id;
  logic                   r_store_valid;
  logic [ROB_WIDTH-1:0]   r_store_rob_id;
  logic                   r_flush;
  logic [31:0]            r_flush_pc;
  logic                   r_busy;
`ifdef COMMIT_COUNTER_EN
  logic [63:0]            r_commit_count;
`endif

  // Reserved type 3 falls through to the REG path.
  always_comb begin
    w_is_store      = 1'b0;
    w_is_mispredict = 1'b0;
    case (headType)
      TYPE_STORE:  w_is_store      = 1'b1;
      TYPE_BRANCH: w_is_mispredict = headMispredict;
      TYPE_REG:    w_is_store      = 1'b0;
      default:     w_is_store      = 1'b0;
    endcase
  end

  assign w_head_fire   = (r_state == ST_RUN) && headValid && headReady;
  assign w_run_pop     = w_head_fire && !w_is_store;
  assign w_store_ack   = (r_state == ST_STORE_WAIT) && storeDone;
  assign w_pop         = (w_run_pop || w_store_ack) && !resetIn;
  assign w_reg_write   = w_run_pop && (headDest != 5'd0);
  assign w_flush_start = w_head_fire && w_is_mispredict;

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      r_state    <= ST_RUN;
      r_walk_idx <= '0;
    end else begin
      r_state    <= w_next_state;
      r_walk_idx <= w_next_walk_idx;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_next_walk_idx = r_walk_idx;
    case (r_state)
      ST_RUN: begin
        if (w_head_fire && w_is_store) begin
          w_next_state = ST_STORE_WAIT;
        end else if (w_flush_start) begin
          w_next_state    = ST_FLUSH;
          w_next_walk_idx = FIRST_CLEAR_IDX;
        end
      end
      ST_STORE_WAIT: begin
        if (storeDone) begin
          w_next_state = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (r_walk_idx == LAST_REG_IDX) begin
          w_next_state    = ST_RUN;
          w_next_walk_idx = '0;
        end else begin
          w_next_walk_idx = r_walk_idx + REG_IDX_W'(1);
        end
      end
      default: begin
        w_next_state    = ST_RUN;
        w_next_walk_idx = '0;
      end
    endcase
  end

  always_comb begin
    headPop          = w_pop;
    regUpdateValid   = r_reg_valid;
    regUpdateDest    = r_reg_dest;
    regValue         = r_reg_value;
    regUpdateRobId   = r_reg_rob_id;
    storeCommitValid = r_store_valid;
    storeCommitRobId = r_store_rob_id;
    flushOut         = r_flush;
    flushPc          = r_flush_pc;
    rfClearValid     = (r_state == ST_FLUSH);
    rfClearIndex     = (r_state == ST_FLUSH) ? r_walk_idx : 5'd0;
    busy             = r_busy;
    o_dbg_state      = r_state;
`ifdef COMMIT_COUNTER_EN
    commitCount      = r_commit_count;
`endif
  end

  // Register-file-facing outputs are zero whenever they are not carrying a commit.
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      r_reg_valid    <= 1'b0;
      r_reg_dest     <= '0;
      r_reg_value    <= '0;
      r_reg_rob_id   <= '0;
      r_store_valid  <= 1'b0;
      r_store_rob_id <= '0;
      r_flush        <= 1'b0;
      r_flush_pc     <= '0;
      r_busy         <= 1'b0;
    end else begin
      r_reg_valid  <= w_reg_write;
      r_reg_dest   <= w_reg_write ? headDest  : 5'd0;
      r_reg_value  <= w_reg_write ? headValue : 32'd0;
      r_reg_rob_id <= w_reg_write ? headRobId : '0;

      r_store_valid <= (w_next_state == ST_STORE_WAIT);
      if (w_head_fire && w_is_store) begin
        r_store_rob_id <= headRobId;
      end else if (w_store_ack) begin
        r_store_rob_id <= '0;
      end

      r_flush    <= w_flush_start;
      r_flush_pc <= w_flush_start ? headTarget : 32'd0;
      r_busy     <= (w_next_state != ST_RUN);
    end
  end

`ifdef COMMIT_COUNTER_EN
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      r_commit_count <= 64'd0;
    end else if (w_pop) begin
      r_commit_count <= r_commit_count + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_commit_controller.sv
// Self-checking bench for commit_controller: vector table for RUN-state retirement,
// hand-written store / mispredict / reset sequences, scoreboard for register-file writes.
module tb_commit_controller;
  import commit_controller_pkg::*;

  localparam int ROB_W = 4;
  localparam int SB_W  = 5 + 32 + ROB_W;

  logic             clockIn = 1'b0;
  logic             resetIn;
  logic             headValid;
  logic             headReady;
  logic [1:0]       headType;
  logic [4:0]       headDest;
  logic [31:0]      headValue;
  logic [ROB_W-1:0] headRobId;
  logic             headMispredict;
  logic [31:0]      headTarget;
  logic             headPop;
  logic             regUpdateValid;
  logic [4:0]       regUpdateDest;
  logic [31:0]      regValue;
  logic [ROB_W-1:0] regUpdateRobId;
  logic             storeCommitValid;
  logic [ROB_W-1:0] storeCommitRobId;
  logic             storeDone;
  logic             flushOut;
  logic [31:0]      flushPc;
  logic             rfClearValid;
  logic [4:0]       rfClearIndex;
  logic             busy;
  state_t           o_dbg_state;
`ifdef COMMIT_COUNTER_EN
  logic [63:0]      commitCount;
`endif

  commit_controller #(.ROB_WIDTH(ROB_W)) dut (
    .clockIn          (clockIn),
    .resetIn          (resetIn),
    .headValid        (headValid),
    .headReady        (headReady),
    .headType         (headType),
    .headDest         (headDest),
    .headValue        (headValue),
    .headRobId        (headRobId),
    .headMispredict   (headMispredict),
    .headTarget       (headTarget),
    .headPop          (headPop),
    .regUpdateValid   (regUpdateValid),
    .regUpdateDest    (regUpdateDest),
    .regValue         (regValue),
    .regUpdateRobId   (regUpdateRobId),
    .storeCommitValid (storeCommitValid),
    .storeCommitRobId (storeCommitRobId),
    .storeDone        (storeDone),
    .flushOut         (flushOut),
    .flushPc          (flushPc),
    .rfClearValid     (rfClearValid),
    .rfClearIndex     (rfClearIndex),
    .busy             (busy),
`ifdef COMMIT_COUNTER_EN
    .commitCount      (commitCount),
`endif
    .o_dbg_state      (o_dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clockIn = ~clockIn;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [63:0] exp_pops = 64'd0;

  always @(posedge clockIn) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [SB_W-1:0] exp_q[$];
  int              due_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_write(input logic [4:0] dest, input logic [31:0] value, input logic [ROB_W-1:0] rid);
    exp_q.push_back({dest, value, rid});
    due_q.push_back(cyc + 1);
  endtask

  always @(negedge clockIn) begin
    logic [SB_W-1:0] got;
    logic [SB_W-1:0] req;
    got = {regUpdateDest, regValue, regUpdateRobId};
    if (regUpdateValid) begin
      checks++;
      if (exp_q.size() == 0 || due_q[0] != cyc) begin
        failures++;
        $display("FAIL reg_write_unexpected actual=0x%0h required=no write (cycle %0d)", got, cyc);
      end else begin
        req = exp_q.pop_front();
        void'(due_q.pop_front());
        if (got !== req) begin
          failures++;
          $display("FAIL reg_write_data actual=0x%0h required=0x%0h (cycle %0d)", got, req, cyc);
        end
      end
    end else if (exp_q.size() != 0 && due_q[0] == cyc) begin
      checks++;
      failures++;
      req = exp_q.pop_front();
      void'(due_q.pop_front());
      $display("FAIL reg_write_missing actual=no write required=0x%0h (cycle %0d)", req, cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_head(input logic v, input logic r, input logic [1:0] typ, input logic [4:0] dest,
                            input logic [31:0] value, input logic [ROB_W-1:0] rid, input logic mis,
                            input logic [31:0] target, input logic done);
    headValid      = v;
    headReady      = r;
    headType       = typ;
    headDest       = dest;
    headValue      = value;
    headRobId      = rid;
    headMispredict = mis;
    headTarget     = target;
    storeDone      = done;
  endtask

  task automatic drive_idle();
    drive_head(1'b0, 1'b0, TYPE_REG, 5'd0, 32'd0, '0, 1'b0, 32'd0, 1'b0);
  endtask

  typedef struct {
    logic             valid;
    logic             ready;
    logic [1:0]       typ;
    logic [4:0]       dest;
    logic [31:0]      value;
    logic [ROB_W-1:0] rid;
    logic             done;
    logic             exp_pop;
    logic             exp_write;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic r, input logic [1:0] typ, input logic [4:0] dest,
                              input logic [31:0] value, input logic [ROB_W-1:0] rid, input logic done,
                              input logic exp_pop, input logic exp_write);
    vec_t x;
    x.valid = v; x.ready = r; x.typ = typ; x.dest = dest; x.value = value;
    x.rid = rid; x.done = done; x.exp_pop = exp_pop; x.exp_write = exp_write;
    return x;
  endfunction

  // Called at a negedge; returns at the next negedge.
  task automatic apply(input vec_t v);
    drive_head(v.valid, v.ready, v.typ, v.dest, v.value, v.rid, 1'b0, 32'd0, v.done);
    #1;
    check("head_pop", {63'd0, headPop}, {63'd0, v.exp_pop});
    if (v.exp_write) expect_write(v.dest, v.value, v.rid);
    if (v.exp_pop) exp_pops++;
    @(negedge clockIn);
  endtask

  task automatic check_reset_state();
    check("rst_reg_valid",   {63'd0, regUpdateValid}, 64'd0);
    check("rst_reg_dest",    {59'd0, regUpdateDest}, 64'd0);
    check("rst_reg_value",   {32'd0, regValue}, 64'd0);
    check("rst_reg_rob",     {60'd0, regUpdateRobId}, 64'd0);
    check("rst_store_valid", {63'd0, storeCommitValid}, 64'd0);
    check("rst_store_rob",   {60'd0, storeCommitRobId}, 64'd0);
    check("rst_flush",       {63'd0, flushOut}, 64'd0);
    check("rst_flush_pc",    {32'd0, flushPc}, 64'd0);
    check("rst_clear_valid", {63'd0, rfClearValid}, 64'd0);
    check("rst_clear_index", {59'd0, rfClearIndex}, 64'd0);
    check("rst_busy",        {63'd0, busy}, 64'd0);
    check("rst_state",       {62'd0, o_dbg_state}, {62'd0, ST_RUN});
    check("rst_pop",         {63'd0, headPop}, 64'd0);
  endtask

  task automatic run_store(input logic [ROB_W-1:0] rid, input int n_wait);
    drive_head(1'b1, 1'b1, TYPE_STORE, 5'd4, 32'hDEAD_0000, rid, 1'b0, 32'd0, 1'b0);
    #1;
    check("store_entry_pop", {63'd0, headPop}, 64'd0);
    @(negedge clockIn);
    for (int k = 1; k <= n_wait; k++) begin
      check("store_valid", {63'd0, storeCommitValid}, 64'd1);
      check("store_rob_id", {60'd0, storeCommitRobId}, {60'd0, rid});
      check("store_busy", {63'd0, busy}, 64'd1);
      headRobId = rid ^ 4'hF;
      storeDone = (k == n_wait);
      #1;
      check("store_pop", {63'd0, headPop}, {63'd0, (k == n_wait)});
      if (k == n_wait) exp_pops++;
      @(negedge clockIn);
    end
    drive_idle();
    #1;
    check("store_released", {63'd0, storeCommitValid}, 64'd0);
    check("store_busy_clear", {63'd0, busy}, 64'd0);
    check("store_no_repop", {63'd0, headPop}, 64'd0);
    @(negedge clockIn);
  endtask

  task automatic run_mispredict(input logic [4:0] dest, input logic [31:0] value, input logic [31:0] target,
                                input logic [ROB_W-1:0] rid, input bit resume);
    drive_head(1'b1, 1'b1, TYPE_BRANCH, dest, value, rid, 1'b1, target, 1'b0);
    #1;
    check("mispredict_pop", {63'd0, headPop}, 64'd1);
    exp_pops++;
    if (dest != 5'd0) expect_write(dest, value, rid);
    @(negedge clockIn);
    // Stale head left by the flushing ROB; it must not be retired during the walk.
    drive_head(1'b1, 1'b1, TYPE_REG, 5'd20, 32'h0000_00AA, 4'd7, 1'b0, 32'd0, 1'b0);
    for (int i = 1; i <= 31; i++) begin
      check("flush_out", {63'd0, flushOut}, {63'd0, (i == 1)});
      if (i == 1) check("flush_pc", {32'd0, flushPc}, {32'd0, target});
      check("clear_valid", {63'd0, rfClearValid}, 64'd1);
      check("clear_index", {59'd0, rfClearIndex}, i);
      check("walk_busy", {63'd0, busy}, 64'd1);
      #1;
      check("walk_no_pop", {63'd0, headPop}, 64'd0);
      @(negedge clockIn);
    end
    check("walk_done_clear", {63'd0, rfClearValid}, 64'd0);
    check("walk_done_busy", {63'd0, busy}, 64'd0);
    check("walk_done_flush", {63'd0, flushOut}, 64'd0);
    if (!resume) drive_idle();
    #1;
    check("resume_pop", {63'd0, headPop}, {63'd0, resume});
    if (resume) begin
      exp_pops++;
      expect_write(5'd20, 32'h0000_00AA, 4'd7);
    end
    @(negedge clockIn);
    drive_idle();
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs[14];

  initial begin
    logic [31:0] r0, r1, r2, r3;
    r0 = $urandom();
    r1 = $urandom();
    r2 = $urandom();
    r3 = 32'($urandom_range(1, 32'hFFFF));

    resetIn = 1'b1;
    drive_idle();
    repeat (2) @(negedge clockIn);
    check_reset_state();
    resetIn = 1'b0;
    exp_pops = 64'd0;
    @(negedge clockIn);

    // Head not ready for 5 cycles, then ready; three REG heads 5/6/0; RUN-state corner cases.
    for (int i = 0; i < 5; i++) vecs[i] = mk(1, 0, TYPE_REG, 5'd7, 32'h77, 4'd1, 0, 0, 0);
    vecs[5]  = mk(1, 1, TYPE_REG,    5'd7,  r0,           4'd1, 0, 1, 1);
    vecs[6]  = mk(1, 1, TYPE_REG,    5'd5,  32'h11,       4'd2, 0, 1, 1);
    vecs[7]  = mk(1, 1, TYPE_REG,    5'd6,  32'h22,       4'd3, 0, 1, 1);
    vecs[8]  = mk(1, 1, TYPE_REG,    5'd0,  32'h33,       4'd4, 0, 1, 0);
    vecs[9]  = mk(0, 0, TYPE_STORE,  5'd0,  32'h0,        4'd0, 1, 0, 0);
    vecs[10] = mk(1, 1, TYPE_BRANCH, 5'd9,  r1,           4'd5, 0, 1, 1);
    vecs[11] = mk(1, 1, TYPE_BRANCH, 5'd0,  32'h99,       4'd6, 0, 1, 0);
    vecs[12] = mk(1, 1, 2'd3,        5'd12, r2,           4'd7, 0, 1, 1);
    vecs[13] = mk(0, 1, TYPE_REG,    5'd13, 32'h5,        4'd8, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i]);
      check("table_busy", {63'd0, busy}, 64'd0);
      check("table_store_valid", {63'd0, storeCommitValid}, 64'd0);
      check("table_flush", {63'd0, flushOut}, 64'd0);
    end
    drive_idle();

    run_store(4'd3, 4);
    run_mispredict(5'd1, 32'h104, 32'h200, 4'd9, 1'b1);

    // Reset in the middle of the walk, at clear index 10.
    drive_head(1'b1, 1'b1, TYPE_BRANCH, 5'd0, 32'd0, 4'd1, 1'b1, 32'h400, 1'b0);
    #1;
    check("mid_flush_pop", {63'd0, headPop}, 64'd1);
    @(negedge clockIn);
    drive_head(1'b1, 1'b1, TYPE_REG, 5'd21, 32'hBB, 4'd2, 1'b0, 32'd0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      check("mid_flush_index", {59'd0, rfClearIndex}, i);
      if (i == 10) begin
        resetIn = 1'b1;
        drive_idle();
      end
      @(negedge clockIn);
    end
    check_reset_state();
    resetIn = 1'b0;
    exp_pops = 64'd0;
    apply(mk(1, 1, TYPE_REG, 5'd3, r3, 4'd2, 0, 1, 1));
    drive_idle();
    check("post_flush_reset_busy", {63'd0, busy}, 64'd0);

    // Reset while a store is waiting on the LSB: abandoned without a pop.
    drive_head(1'b1, 1'b1, TYPE_STORE, 5'd0, 32'd0, 4'd9, 1'b0, 32'd0, 1'b0);
    #1;
    check("mid_store_entry_pop", {63'd0, headPop}, 64'd0);
    @(negedge clockIn);
    check("mid_store_valid", {63'd0, storeCommitValid}, 64'd1);
    resetIn = 1'b1;
    #1;
    check("mid_store_reset_pop", {63'd0, headPop}, 64'd0);
    drive_idle();
    @(negedge clockIn);
    check_reset_state();
    resetIn = 1'b0;
    exp_pops = 64'd0;
    apply(mk(1, 1, TYPE_REG, 5'd8, 32'h8888, 4'd4, 0, 1, 1));
    drive_idle();

`ifdef COMMIT_COUNTER_EN
    resetIn = 1'b1;
    @(negedge clockIn);
    resetIn = 1'b0;
    exp_pops = 64'd0;
    check("count_after_reset", commitCount, 64'd0);
    apply(mk(1, 1, TYPE_REG, 5'd10, 32'hA, 4'd1, 0, 1, 1));
    apply(mk(1, 1, TYPE_REG, 5'd0,  32'hB, 4'd2, 0, 1, 0));
    drive_idle();
    run_store(4'd3, 1);
    run_mispredict(5'd11, 32'hC, 32'h300, 4'd4, 1'b0);
    check("commit_count", commitCount, 64'd4);
    check("commit_count_model", commitCount, exp_pops);
`endif

    repeat (3) @(negedge clockIn);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
